seven_segment_scan_controller: RTL
==================================

# seven_segment_scan_controller

Sequences the shared seven_segment_decoder across a 3-digit common-anode display for the 4x4 multiplier's 8-bit product. It converts each accepted product to BCD with a serial double-dabble engine and holds the result in a display register. It then time-multiplexes one 4-bit digit code at a time into the single decoder while driving the matching anode. It sits between the multiplier output register and the decoder/anode pins.

## Interface
- SCAN_DIV, default 50000: clock cycles per digit slot; legal range ≥ 2.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- value  input  8  unsigned product to display (0..255).
- load  input  1  request to convert and display `value`; sampled only when `busy`=0.
- busy  output  1  conversion in progress; `load` is ignored while high.
- digit_code  output  4  BCD digit for the shared decoder; 4'hF means blank (decoder default = all segments off).
- anode  output  3  digit enables, active-low, one-hot-low; bit0 = units, bit1 = tens, bit2 = hundreds.

## Operation
- Conversion FSM has three states: IDLE, SHIFT and COMMIT.
  - IDLE: if `load`=1, capture `value` into the shift register, clear the BCD scratch and the bit counter, and go to SHIFT.
  - SHIFT: 8 cycles. Each cycle, add 3 to any BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After the 8th shift, go to COMMIT.
  - COMMIT: 1 cycle. Copy the scratch into the display register {hund[3:0], tens[3:0], units[3:0]}, then go to IDLE.
- `busy` = (state != IDLE).
- `load` in SHIFT/COMMIT is dropped, not queued.
- Scan prescaler counts 0..SCAN_DIV-1 and wraps. The tick fires when the count equals SCAN_DIV-1.
- Digit index is 2 bits with sequence 0→1→2→0 and advances on tick. Index value 3 is unreachable; if entered, force it to 0.
- `anode` and `digit_code` are combinational from the digit index and display register:
  - index 0 → anode 3'b110, units.
  - index 1 → anode 3'b101, tens.
  - index 2 → anode 3'b011, hund.
- A display-register update appears on the current slot immediately. There is no scan restart.
- The scan runs continuously, independent of conversion.
- Reset values:
  - state IDLE, `busy`=0.
  - display register, scratch and counters all 0.
  - `anode`=3'b110, `digit_code`=4'h0.
- Reset mid-conversion aborts the conversion. The display register is cleared and the partial result is discarded.

## Timing
- `load` sampled high at edge k (IDLE):
  - `busy`=1 after edges k..k+8.
  - Display register holds the new value after edge k+9.
  - `busy`=0 after edge k+9.
- A new `load` is accepted at edge k+10 at the earliest. Maximum sustained rate is one conversion per 10 cycles.
- Each slot lasts exactly SCAN_DIV cycles. Full refresh period is 3·SCAN_DIV cycles.
- Simultaneous tick and COMMIT: the index advance and the display update both take effect on the same edge.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - hund is shown as 4'hF when hund=0.
  - tens is shown as 4'hF when hund=0 and tens=0.
  - units is never blanked. Anodes still scan normally.
- LEADING_ZERO_BLANK_EN undefined: all three digits are always shown, e.g. 7 displays "007".

## Structure
- Package seven_seg_pkg holds:
  - the conversion state enum {IDLE, SHIFT, COMMIT};
  - NUM_DIGITS=3;
  - BLANK_CODE=4'hF;
  - the anode one-hot constants per digit index.
- Sub-module bin8_to_bcd_seq contains the FSM, the double-dabble datapath and the `busy`/done pulse. The top module keeps the display register, prescaler, digit index and mux.

## Test plan
- Reset: assert `rst` for 2 cycles → `busy`=0, `anode`=3'b110, `digit_code`=0, and all slots show 0 across one refresh period.
- `value`=225 with `load` pulsed at edge k, SCAN_DIV=4 → `busy` high for exactly 9 cycles. From edge k+10, slots show units 5, tens 2, hund 2 with anodes 110/101/011, each held 4 cycles.
- `load` with `value`=99 while converting 255 → 99 is ignored. Display becomes 2,5,5 and `busy` drops after 10 cycles total.
- `value`=7, SCAN_DIV=4, LEADING_ZERO_BLANK_EN defined → `digit_code` sequence 7, F, F. With the macro undefined → 7, 0, 0.
- `rst` asserted during cycle 4 of SHIFT while converting 144 → `busy`=0 and display 0,0,0 after that edge. A later `load` with 144 yields 1,4,4.
- Scan wrap, SCAN_DIV=2 → index changes every 2 cycles in order 0,1,2,0, with no cycle showing two anodes low or all anodes high.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and constants for the 3-digit seven-segment scan controller.
//   conv_state_t : conversion FSM states (IDLE, SHIFT, COMMIT)
//   NUM_DIGITS   : number of scanned digits
//   BLANK_CODE   : digit code that the decoder renders as all segments off
//   ANODE_*      : active-low one-hot anode patterns per digit index
//   dd_adjust()  : double-dabble "add 3 to every BCD nibble >= 5" step
package seven_seg_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
    localparam int NUM_DIGITS = 3;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [2:0] ANODE_UNITS = 3'b110;
    localparam logic [2:0] ANODE_TENS = 3'b101;
    localparam logic [2:0] ANODE_HUND = 3'b011;
    localparam logic [2:0] ANODE_OFF = 3'b111;

    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
        return r;
    endfunction
endpackage

// File: rtl/bin8_to_bcd_seq.sv
// bin8_to_bcd_seq: serial double-dabble converter, 8-bit binary to 3-digit BCD.
//   clk, rst  : clock, synchronous active-high reset
//   i_value   : binary value captured when i_load is seen in IDLE
//   i_load    : start request, ignored while o_busy is high
//   o_busy    : conversion in progress (state != IDLE)
//   o_done    : one-cycle pulse while the result in o_bcd is final (COMMIT)
//   o_bcd     : {hund, tens, units} scratch register
module bin8_to_bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_done,
    output logic [11:0] o_bcd
);
    import seven_seg_pkg::*;

    conv_state_t r_state;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic [11:0] w_adj;

    assign w_adj  = dd_adjust(r_bcd);
    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == COMMIT);
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_load) begin
                    r_bin   <= i_value;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    // {bcd, bin} shifted left as one 20-bit register after the adjust step
                    r_bcd   <= {w_adj[10:0], r_bin[7]};
                    r_bin   <= {r_bin[6:0], 1'b0};
                    r_cnt   <= r_cnt + 3'd1;
                    r_state <= (r_cnt == 3'd7) ? COMMIT : SHIFT;
                end
                COMMIT: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: converts an 8-bit product to BCD and scans it over a
// 3-digit common-anode display through a single shared seven-segment decoder.
//   SCAN_DIV   : clock cycles per digit slot (>= 2)
//   clk, rst   : clock, synchronous active-high reset
//   value      : unsigned product to display
//   load       : convert-and-display request, sampled only while busy = 0
//   busy       : conversion in progress
//   digit_code : BCD digit for the decoder, 4'hF = blank
//   anode      : active-low digit enables, bit0 units, bit1 tens, bit2 hundreds
// Optional feature macro LEADING_ZERO_BLANK_EN: blanks leading zero hundreds/tens digits.
module seven_segment_scan_controller #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [3:0] digit_code,
    output logic [2:0] anode
);
    import seven_seg_pkg::*;

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [11:0]      r_disp;
    logic [11:0]      w_bcd;
    logic             w_done;
    logic             w_tick;
    logic [3:0]       w_units;
    logic [3:0]       w_tens;
    logic [3:0]       w_hund;

    bin8_to_bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_value (value),
        .i_load  (load),
        .o_busy  (busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_idx  <= '0;
            r_disp <= '0;
        end else begin
            r_div  <= w_tick ? '0 : r_div + 1'b1;
            // index 3 is never produced by the sequence; recover from it unconditionally
            r_idx  <= (r_idx == 2'd3) ? 2'd0 : w_tick ? ((r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1) : r_idx;
            if (w_done)
                r_disp <= w_bcd;
        end
    end

    assign w_units = r_disp[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    assign w_hund = (r_disp[11:8] == 4'd0) ? BLANK_CODE : r_disp[11:8];
    assign w_tens = (r_disp[11:4] == 8'd0) ? BLANK_CODE : r_disp[7:4];
`else
    assign w_hund = r_disp[11:8];
    assign w_tens = r_disp[7:4];
`endif

    always_comb begin
        anode      = (r_idx == 2'd0) ? ANODE_UNITS :
                     (r_idx == 2'd1) ? ANODE_TENS  :
                     (r_idx == 2'd2) ? ANODE_HUND  : ANODE_OFF;
        digit_code = (r_idx == 2'd0) ? w_units :
                     (r_idx == 2'd1) ? w_tens  :
                     (r_idx == 2'd2) ? w_hund  : BLANK_CODE;
    end
endmodule
